// File: rtl/ad9224_capture_ctrl.sv
// ad9224_capture_ctrl: arms on start, waits for the trigger plus pipeline latency,
// then writes a decimated burst of AD9224 samples to consecutive buffer addresses.
module ad9224_capture_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              trig_mode_i,
  input  logic              trig_in_i,
  input  logic [7:0]        decim_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [11:0]       adc_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0] FLUSH_LD = 8'(PIPE_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mode_q, mode_d;
  logic [7:0]        decim_q, decim_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              trig_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // cnt_q serves as the flush countdown and then the decimation counter; flush
  // always ends at zero, so the first capture cycle stores a sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    decim_d   = decim_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    if (abort_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE, S_DONE: if (start_i) begin
        mode_d    = trig_mode_i;
        decim_d   = decim_i;
        len_d     = (length_i > DEPTH) ? DEPTH : length_i;
        count_d   = '0;
        wr_addr_d = '0;
        ptr_d     = '0;
        cnt_d     = '0;
        state_d   = (length_i == '0) ? S_DONE : S_ARMED;
      end
      S_ARMED: if (!mode_q || (trig_in_i && !trig_q)) begin
        state_d = S_FLUSH;
        cnt_d   = FLUSH_LD;
      end
      S_FLUSH: if (cnt_q == '0) state_d = S_CAPT;
               else cnt_d = cnt_q - 8'd1;
      S_CAPT: if (cnt_q == '0) begin
        wr_en_d   = 1'b1;
        wr_data_d = adc_data_i;
        wr_addr_d = ptr_q;
        ptr_d     = ptr_q + 1'b1;
        count_d   = count_q + 1'b1;
        cnt_d     = decim_q;
        if (count_d == len_q) state_d = S_DONE;
      end else cnt_d = cnt_q - 8'd1;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ARMED) || (state_d == S_FLUSH) || (state_d == S_CAPT);
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      mode_q    <= 1'b0;
      decim_q   <= '0;
      len_q     <= '0;
      trig_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
      decim_q   <= decim_d;
      len_q     <= len_d;
      trig_q    <= trig_in_i;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign count_o   = count_q;
endmodule
